tlk2711_tx_sched: RTL and testbench

Per-file TX scheduler for the TLK2711 transmit path. It latches a file transfer request (base address, byte length, mode) and splits the file into fixed-size frames. It derives the frame count/tail parameters for the TX data block and issues one DMA read command per frame under an outstanding-command limit. It launches the TX data block, then reports completion when the TX data block raises its end-of-file interrupt.

---
 rtl/tlk2711_tx_sched.sv | 196 +++++++++++++++++++
 tb/tb_tlk2711_tx_sched.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlk2711_tx_sched.sv
// rtl/tlk2711_tx_sched.sv - per-file TX scheduler: frame split, DMA read issue, completion
// Splits one file into BODY_BYTES frames, issues one DMA read per frame, then waits for end-of-file.
module tlk2711_tx_sched #(
  parameter int ADDR_WIDTH      = 48,
  parameter int LEN_WIDTH       = 24,
  parameter int BODY_BYTES      = 870,
  parameter int REQ_BYTES       = 872,
  parameter int FRAME_STRIDE    = 872,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_soft_reset,
  input  logic                  i_start,
  input  logic [3:0]            i_tx_mode,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_file_len,
  output logic                  o_tx_start,
  output logic [3:0]            o_tx_mode,
  output logic [15:0]           o_tx_packet_body,
  output logic [15:0]           o_tx_packet_tail,
  output logic [15:0]           o_tx_body_num,
  output logic                  o_dma_cmd_valid,
  input  logic                  i_dma_cmd_ready,
  output logic [ADDR_WIDTH-1:0] o_dma_cmd_addr,
  output logic [15:0]           o_dma_cmd_len,
  input  logic                  i_dma_cmd_done,
  input  logic                  i_tx_interrupt,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err_len,
  output logic [15:0]           o_cmd_cnt
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [2:0] {IDLE, CALC, LAUNCH, ISSUE, WAIT_TX, TEST_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [3:0]            mode_q, mode_d;
  logic [15:0]           body_num_q, body_num_d;
  logic [15:0]           tail_q, tail_d;
  logic [15:0]           cmd_cnt_q, cmd_cnt_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  valid_q, valid_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  irq_q, irq_d;
  logic                  accept;
  logic                  can_issue;

  assign accept = valid_q & i_dma_cmd_ready;

  // A done pulse with nothing outstanding is spurious and dropped.
  always_comb begin
    out_d = out_q;
    if (accept && !i_dma_cmd_done) begin
      out_d = out_q + OW'(1);
    end else if (!accept && i_dma_cmd_done && (out_q != '0)) begin
      out_d = out_q - OW'(1);
    end
  end

  // Valid for next cycle is decided against next cycle's outstanding count.
  assign can_issue = (out_d < OW'(MAX_OUTSTANDING));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    mode_d     = mode_q;
    body_num_d = body_num_q;
    tail_d     = tail_q;
    cmd_cnt_d  = cmd_cnt_q;
    irq_d      = irq_q;
    valid_d    = 1'b0;
    start_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if ((state_q == CALC || state_q == LAUNCH || state_q == ISSUE) && i_tx_interrupt) begin
      irq_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          mode_d    = i_tx_mode;
          addr_d    = i_base_addr;
          cmd_cnt_d = '0;
          irq_d     = 1'b0;
          if (i_tx_mode != 4'd0) begin
            state_d = TEST_RUN;
            start_d = 1'b1;
          end else if (i_file_len == '0) begin
            err_d = 1'b1;
          end else begin
            state_d    = CALC;
            rem_d      = i_file_len;
            body_num_d = '0;
          end
        end
      end
      CALC: begin
        if (rem_q > LEN_WIDTH'(BODY_BYTES)) begin
          rem_d      = rem_q - LEN_WIDTH'(BODY_BYTES);
          body_num_d = body_num_q + 16'd1;
        end else begin
          tail_d  = rem_q[15:0];
          state_d = LAUNCH;
          start_d = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = ISSUE;
        valid_d = can_issue;
      end
      ISSUE: begin
        if (accept) begin
          addr_d    = addr_q + ADDR_WIDTH'(FRAME_STRIDE);
          cmd_cnt_d = cmd_cnt_q + 16'd1;
          if (cmd_cnt_q == body_num_q) begin
            state_d = WAIT_TX;
          end else begin
            valid_d = can_issue;
          end
        end else if (valid_q) begin
          valid_d = 1'b1;
        end else begin
          valid_d = can_issue;
        end
      end
      WAIT_TX: begin
        if (i_tx_interrupt || irq_q) begin
          done_d  = 1'b1;
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      TEST_RUN: begin
        state_d = TEST_RUN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || i_soft_reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      mode_q     <= '0;
      body_num_q <= '0;
      tail_q     <= '0;
      cmd_cnt_q  <= '0;
      out_q      <= '0;
      irq_q      <= 1'b0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      mode_q     <= mode_d;
      body_num_q <= body_num_d;
      tail_q     <= tail_d;
      cmd_cnt_q  <= cmd_cnt_d;
      out_q      <= out_d;
      irq_q      <= irq_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_tx_start       = start_q;
  assign o_tx_mode        = mode_q;
  assign o_tx_packet_body = 16'(BODY_BYTES);
  assign o_tx_packet_tail = tail_q;
  assign o_tx_body_num    = body_num_q;
  assign o_dma_cmd_valid  = valid_q;
  assign o_dma_cmd_addr   = addr_q;
  assign o_dma_cmd_len    = 16'(REQ_BYTES);
  assign o_busy           = (state_q != IDLE);
  assign o_done           = done_q;
  assign o_err_len        = err_q;
  assign o_cmd_cnt        = cmd_cnt_q;

endmodule

// File: tb/tb_tlk2711_tx_sched.sv
// tb/tb_tlk2711_tx_sched.sv - directed and randomized checks of the TX file scheduler
// Reference: frame count/tail by division, frame addresses by multiplication, outstanding by counting.
module tb_tlk2711_tx_sched;
  logic        clk = 1'b0;
  logic        rst, i_soft_reset, i_start;
  logic [3:0]  i_tx_mode;
  logic [47:0] i_base_addr;
  logic [23:0] i_file_len;
  logic        o_tx_start;
  logic [3:0]  o_tx_mode;
  logic [15:0] o_tx_packet_body, o_tx_packet_tail, o_tx_body_num;
  logic        o_dma_cmd_valid, i_dma_cmd_ready;
  logic [47:0] o_dma_cmd_addr;
  logic [15:0] o_dma_cmd_len;
  logic        i_dma_cmd_done, i_tx_interrupt;
  logic        o_busy, o_done, o_err_len;
  logic [15:0] o_cmd_cnt;

  tlk2711_tx_sched dut (
    .clk(clk), .rst(rst), .i_soft_reset(i_soft_reset), .i_start(i_start),
    .i_tx_mode(i_tx_mode), .i_base_addr(i_base_addr), .i_file_len(i_file_len),
    .o_tx_start(o_tx_start), .o_tx_mode(o_tx_mode), .o_tx_packet_body(o_tx_packet_body),
    .o_tx_packet_tail(o_tx_packet_tail), .o_tx_body_num(o_tx_body_num),
    .o_dma_cmd_valid(o_dma_cmd_valid), .i_dma_cmd_ready(i_dma_cmd_ready),
    .o_dma_cmd_addr(o_dma_cmd_addr), .o_dma_cmd_len(o_dma_cmd_len),
    .i_dma_cmd_done(i_dma_cmd_done), .i_tx_interrupt(i_tx_interrupt),
    .o_busy(o_busy), .o_done(o_done), .o_err_len(o_err_len), .o_cmd_cnt(o_cmd_cnt)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [47:0] exp_base = '0;
  int          n_cmds = 0, exp_k = 0, out_m = 0, ready_pct = 100, done_lat = 0;
  int          exp_bn = 0, exp_tl = 0, starts = 0;
  int          irq_wait = -1, irq_cyc = -1;
  int          done_q[$];
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [47:0] prev_addr = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [47:0] frame_addr(input logic [47:0] base, input int k);
    logic [95:0] a;
    a = {48'd0, base} + 96'(k) * 96'd872;
    return a[47:0];
  endfunction

  // One clock: check outputs, drive the next inputs, advance to the next falling edge.
  task automatic cycle();
    logic acc;
    if (o_tx_start) begin
      starts++;
      chk("start_body_num", 64'(o_tx_body_num), 64'(exp_bn));
      chk("start_tail", 64'(o_tx_packet_tail), 64'(exp_tl));
      chk("start_before_valid", 64'(o_dma_cmd_valid), 64'(0));
      chk("start_before_accept", 64'(exp_k), 64'(0));
    end
    if (o_dma_cmd_valid) chk("valid_limit", 64'(out_m < 4), 64'(1));
    if (prev_valid && !prev_ready) begin
      chk("valid_held", 64'(o_dma_cmd_valid), 64'(1));
      chk("addr_held", 64'(o_dma_cmd_addr), 64'(prev_addr));
    end
    if (exp_k >= n_cmds) chk("no_extra_valid", 64'(o_dma_cmd_valid), 64'(0));
    i_dma_cmd_ready = (int'($urandom_range(0, 99)) < ready_pct);
    acc = o_dma_cmd_valid && i_dma_cmd_ready;
    if (acc) begin
      chk("cmd_addr", 64'(o_dma_cmd_addr), 64'(frame_addr(exp_base, exp_k)));
      chk("cmd_len", 64'(o_dma_cmd_len), 64'(872));
      exp_k++;
      out_m++;
      if (done_lat > 0) done_q.push_back(cyc + done_lat);
    end
    i_dma_cmd_done = 1'b0;
    if (done_q.size() > 0 && done_q[0] <= cyc) begin
      void'(done_q.pop_front());
      i_dma_cmd_done = 1'b1;
      out_m--;
    end
    i_tx_interrupt = 1'b0;
    if (irq_wait >= 0 && exp_k == n_cmds) begin
      if (irq_wait == 0) begin
        i_tx_interrupt = 1'b1;
        irq_cyc = cyc;
      end
      irq_wait--;
    end
    prev_valid = o_dma_cmd_valid;
    prev_ready = i_dma_cmd_ready;
    prev_addr  = o_dma_cmd_addr;
    @(negedge clk);
    cyc++;
  endtask

  task automatic begin_file(input logic [47:0] base, input int len, input int rpct, input int lat);
    exp_bn    = (len - 1) / 870;
    exp_tl    = len - exp_bn * 870;
    n_cmds    = exp_bn + 1;
    exp_k     = 0;
    exp_base  = base;
    ready_pct = rpct;
    done_lat  = lat;
    starts    = 0;
    irq_wait  = -1;
    i_base_addr = base;
    i_file_len  = 24'(len);
    i_tx_mode   = 4'd0;
    i_start     = 1'b1;
    cycle();
    i_start = 1'b0;
  endtask

  task automatic finish_file(input int irq_delay);
    int done_cyc;
    done_cyc = -1;
    irq_wait = irq_delay;
    for (int b = 0; b < 3000 && done_cyc < 0; b++) begin
      cycle();
      if (o_done) done_cyc = cyc;
    end
    chk("done_seen", 64'(done_cyc >= 0), 64'(1));
    chk("done_latency", 64'(done_cyc - irq_cyc), 64'(irq_delay == 0 ? 2 : 1));
    chk("cmd_cnt", 64'(o_cmd_cnt), 64'(n_cmds));
    chk("tx_start_once", 64'(starts), 64'(1));
    chk("busy_after_done", 64'(o_busy), 64'(0));
    cycle();
    chk("done_one_cycle", 64'(o_done), 64'(0));
    for (int b = 0; b < 100 && done_q.size() > 0; b++) cycle();
    chk("dones_drained", 64'(done_q.size()), 64'(0));
  endtask

  task automatic sreset();
    i_soft_reset    = 1'b1;
    i_dma_cmd_ready = 1'b0;
    i_dma_cmd_done  = 1'b0;
    i_start         = 1'b0;
    i_tx_interrupt  = 1'b0;
    @(negedge clk);
    cyc++;
    i_soft_reset = 1'b0;
    out_m = 0; done_q.delete(); exp_k = 0; n_cmds = 0; irq_wait = -1;
    prev_valid = 1'b0; prev_ready = 1'b0;
    chk("srst_valid", 64'(o_dma_cmd_valid), 64'(0));
    chk("srst_cmd_cnt", 64'(o_cmd_cnt), 64'(0));
    chk("srst_busy", 64'(o_busy), 64'(0));
    chk("srst_mode", 64'(o_tx_mode), 64'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] rb;
    int          rl;
    rst = 1'b1; i_soft_reset = 1'b0; i_start = 1'b0; i_tx_mode = 4'd0;
    i_base_addr = '0; i_file_len = '0; i_dma_cmd_ready = 1'b0;
    i_dma_cmd_done = 1'b0; i_tx_interrupt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(o_dma_cmd_valid), 64'(0));
    chk("rst_start", 64'(o_tx_start), 64'(0));
    chk("rst_done", 64'(o_done), 64'(0));
    chk("rst_err", 64'(o_err_len), 64'(0));
    chk("rst_addr", 64'(o_dma_cmd_addr), 64'(0));
    chk("rst_cmd_cnt", 64'(o_cmd_cnt), 64'(0));
    chk("rst_mode", 64'(o_tx_mode), 64'(0));
    chk("rst_body_num", 64'(o_tx_body_num), 64'(0));
    chk("rst_tail", 64'(o_tx_packet_tail), 64'(0));
    chk("rst_body", 64'(o_tx_packet_body), 64'(870));
    chk("rst_busy", 64'(o_busy), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    begin_file(48'h1000, 2610, 100, 2);
    finish_file(3);
    begin_file(48'h2000, 1000, 100, 1);
    finish_file(1);
    begin_file(48'h3000, 870, 100, 3);
    finish_file(0);
    begin_file(48'hFFFF_FFFF_FE00, 3000, 70, 4);
    finish_file(2);

    // ready withheld while a command is pending
    begin_file(48'h4000, 2610, 0, 3);
    for (int b = 0; b < 20 && !o_dma_cmd_valid; b++) cycle();
    chk("hold_valid_seen", 64'(o_dma_cmd_valid), 64'(1));
    repeat (10) cycle();
    chk("hold_no_accept", 64'(exp_k), 64'(0));
    ready_pct = 100;
    cycle();
    chk("hold_single_accept", 64'(exp_k), 64'(1));
    finish_file(1);

    // outstanding limit with no completions
    begin_file(48'h5000, 8700, 100, 0);
    repeat (30) cycle();
    chk("stall_accepts", 64'(exp_k), 64'(4));
    chk("stall_valid_low", 64'(o_dma_cmd_valid), 64'(0));
    done_q.push_back(cyc);
    repeat (20) cycle();
    chk("stall_one_more", 64'(exp_k), 64'(5));
    sreset();

    // soft reset mid-issue, then restart
    begin_file(48'h6000, 8700, 100, 0);
    for (int b = 0; b < 40 && exp_k < 2; b++) cycle();
    chk("abort_two_accepts", 64'(exp_k), 64'(2));
    sreset();
    begin_file(48'h6000, 2610, 100, 2);
    finish_file(1);

    // zero-length request
    i_file_len = '0; i_tx_mode = 4'd0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("zero_err", 64'(o_err_len), 64'(1));
    chk("zero_busy", 64'(o_busy), 64'(0));
    chk("zero_start", 64'(o_tx_start), 64'(0));
    @(negedge clk);
    chk("zero_err_pulse", 64'(o_err_len), 64'(0));
    for (int b = 0; b < 5; b++) begin
      chk("zero_no_valid", 64'(o_dma_cmd_valid), 64'(0));
      chk("zero_idle", 64'(o_busy), 64'(0));
      @(negedge clk);
    end

    // test mode: launch only, no DMA, busy until soft reset
    i_tx_mode = 4'd2; i_file_len = 24'd2610; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("kcode_start", 64'(o_tx_start), 64'(1));
    chk("kcode_mode", 64'(o_tx_mode), 64'(2));
    chk("kcode_busy", 64'(o_busy), 64'(1));
    i_tx_mode = 4'd0; i_file_len = 24'd870; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int b = 0; b < 8; b++) begin
      chk("kcode_no_valid", 64'(o_dma_cmd_valid), 64'(0));
      chk("kcode_no_restart", 64'(o_tx_start), 64'(0));
      chk("kcode_held", 64'(o_tx_mode), 64'(2));
      chk("kcode_still_busy", 64'(o_busy), 64'(1));
      @(negedge clk);
    end
    sreset();

    for (int t = 0; t < 8; t++) begin
      rb = {16'($urandom), $urandom};
      rl = (t % 2 == 0) ? 870 * int'($urandom_range(1, 10)) : int'($urandom_range(1, 12000));
      begin_file(rb, rl, int'($urandom_range(30, 100)), int'($urandom_range(1, 8)));
      finish_file(int'($urandom_range(0, 4)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
